sc_goalcontroller: RTL
======================

# sc_goalcontroller

Sequencer for the Frogger goal row. Generates the wall/entry mask that feeds the goal-row entry comparator, tracks which of the two homes (left = bit 5, right = bit 2) are occupied, and samples the comparator's active-low lose/enterLeft/enterRight results once the frog reaches the top row. From those results it issues frog-home, frog-dead and level-clear events to the game FSM. It sits between the game-state controller and the comparator, and is the only driver of the comparator's entryBUS.

## Interface
- GOALCTRL_DATAWIDTH, 8, width of entry mask and row buses
- GOALCTRL_SAMPLE_DELAY, 2, cycles to wait after frog arrival before sampling comparator (≥1)
- GOALCTRL_HOLD_CYCLES, 4, cycles to hold in post-event state before re-arming (≥1)

- SC_GOALCTRL_CLOCK_50  in  1  system clock, all state on rising edge
- SC_GOALCTRL_RESET_InHigh  in  1  asynchronous, active-high reset
- SC_GOALCTRL_start_InHigh  in  1  begin play (sampled in IDLE only)
- SC_GOALCTRL_stop_InHigh  in  1  game over; synchronous return to IDLE from any state
- SC_GOALCTRL_frogAtTop_InHigh  in  1  level: frog currently in goal row
- SC_GOALCTRL_lose_InLow  in  1  comparator lose result
- SC_GOALCTRL_enterLeft_InLow  in  1  comparator left-home result
- SC_GOALCTRL_enterRight_InLow  in  1  comparator right-home result
- SC_GOALCTRL_entryBUS_Out  out  DATAWIDTH  registered mask to comparator
- SC_GOALCTRL_homeFilled_Out  out  2  [1]=left, [0]=right occupied
- SC_GOALCTRL_frogHome_OutHigh  out  1  one-cycle pulse, frog scored
- SC_GOALCTRL_frogDead_OutHigh  out  1  one-cycle pulse, frog lost in goal row
- SC_GOALCTRL_levelClear_OutHigh  out  1  one-cycle pulse, both homes filled and cleared
- SC_GOALCTRL_level_Out  out  4  level counter
- SC_GOALCTRL_busy_OutHigh  out  1  high in every state except IDLE and ARMED

## Operation
- Base mask 8'b11011011 (walls everywhere except home bits 5 and 2). A filled home sets its bit: left → bit 5, right → bit 2. The mask is always base | {filled bits}.
- States:
  - IDLE: entryBUS=0, so the comparator is inactive and never reports lose. start → ARMED, with entryBUS = base and homeFilled = 00.
  - ARMED: frogAtTop=1 → SETTLE, counter loaded with SAMPLE_DELAY.
  - SETTLE: counts down. If frogAtTop drops, return to ARMED with no event. At count 0 → DECIDE.
  - DECIDE: one cycle; samples the comparator and selects the result:
    - lose_InLow=0 → dead.
    - Else enterLeft_InLow=0 and left home empty → fill left.
    - Else enterRight_InLow=0 and right home empty → fill right.
    - Else → dead (frog in gap or no entry).
    - Left has priority if both enter lines are low.
  - RESULT: one cycle. Asserts frogHome or frogDead. On a fill, homeFilled and entryBUS update on this same cycle. → HOLD.
  - HOLD: HOLD_CYCLES cycles → WAIT_CLEAR.
  - WAIT_CLEAR: waits for frogAtTop=0. Then → CLEAR if homeFilled=11, else → ARMED.
  - CLEAR: one cycle. levelClear=1, homeFilled←00, entryBUS←base, level←level+1 (wraps 15→0). → ARMED.
- stop=1 in any state → IDLE next cycle, with all outputs at their reset values except level, which holds. stop and start in the same cycle: stop wins.
- start outside IDLE is ignored.
- Comparator inputs are ignored in every state except DECIDE.

## Timing
- Reset (async, immediate): state=IDLE, entryBUS=0, homeFilled=00, frogHome=frogDead=levelClear=0, level=0, busy=0.
- start sampled high at edge N: state is ARMED and entryBUS=8'b11011011 from cycle N+1.
- frogAtTop sampled high in ARMED at edge T:
  - SETTLE during T+1 … T+SAMPLE_DELAY.
  - DECIDE at T+SAMPLE_DELAY+1.
  - Event pulse at T+SAMPLE_DELAY+2.
- Pulse width is exactly one cycle. Only one event pulse is asserted per cycle.
- HOLD occupies the HOLD_CYCLES cycles after the pulse. WAIT_CLEAR then lasts at least one cycle.
- levelClear occurs the cycle after frogAtTop is seen low, provided both homes are filled.
- Reset asserted mid-SETTLE/HOLD: outputs are at reset values within the same cycle. No partial event is emitted after release.

## Test plan
- Reset during HOLD → all outputs zero immediately. After release, state is IDLE and entryBUS=0 until start.
- start, then frogAtTop with lose=1, enterLeft=0, enterRight=1 → frogHome pulse 4 cycles after arrival (SAMPLE_DELAY=2). homeFilled=10, entryBUS=8'b11111011.
- With left filled, frog arrives and the comparator reports lose=0 → frogDead pulse. homeFilled stays 10.
- Fill right after left, drop frogAtTop → levelClear pulse. homeFilled=00, entryBUS=8'b11011011, level=1.
- frogAtTop high for 1 cycle only (drops in SETTLE) → no pulse, state returns to ARMED.
- stop asserted together with start in IDLE, and stop asserted in RESULT → stays in or returns to IDLE, entryBUS=0, level unchanged. Wrap check: 16 level clears → level=0.

Source files
------------

// File: rtl/sc_goalcontroller.sv
// Frogger goal-row sequencer: drives the comparator entry mask, tracks the left/right homes, emits home/dead/clear events.
// Latency: event pulse two cycles after SETTLE ends (arrival edge + SAMPLE_DELAY + 2); levelClear one cycle after frog leaves the row.
// Backpressure: none; stop forces IDLE on the next edge from any state, start is honoured only in IDLE.
//
// Ports:
//   SC_GOALCTRL_CLOCK_50 / SC_GOALCTRL_RESET_InHigh     clock, async active-high reset
//   SC_GOALCTRL_start_InHigh / SC_GOALCTRL_stop_InHigh  play control from the game-state controller
//   SC_GOALCTRL_frogAtTop_InHigh                        frog currently in the goal row (level)
//   SC_GOALCTRL_lose/enterLeft/enterRight_InLow         comparator results, sampled only in DECIDE
//   SC_GOALCTRL_entryBUS_Out                            registered wall/entry mask to the comparator
//   SC_GOALCTRL_homeFilled_Out                          [1]=left home, [0]=right home occupied
//   SC_GOALCTRL_frogHome/frogDead/levelClear_OutHigh    one-cycle event pulses
//   SC_GOALCTRL_level_Out / SC_GOALCTRL_busy_OutHigh    level counter, busy outside IDLE/ARMED
module sc_goalcontroller #(
  parameter int GOALCTRL_DATAWIDTH    = 8,
  parameter int GOALCTRL_SAMPLE_DELAY = 2,
  parameter int GOALCTRL_HOLD_CYCLES  = 4
) (
  input  logic                          SC_GOALCTRL_CLOCK_50,
  input  logic                          SC_GOALCTRL_RESET_InHigh,
  input  logic                          SC_GOALCTRL_start_InHigh,
  input  logic                          SC_GOALCTRL_stop_InHigh,
  input  logic                          SC_GOALCTRL_frogAtTop_InHigh,
  input  logic                          SC_GOALCTRL_lose_InLow,
  input  logic                          SC_GOALCTRL_enterLeft_InLow,
  input  logic                          SC_GOALCTRL_enterRight_InLow,
  output logic [GOALCTRL_DATAWIDTH-1:0] SC_GOALCTRL_entryBUS_Out,
  output logic [1:0]                    SC_GOALCTRL_homeFilled_Out,
  output logic                          SC_GOALCTRL_frogHome_OutHigh,
  output logic                          SC_GOALCTRL_frogDead_OutHigh,
  output logic                          SC_GOALCTRL_levelClear_OutHigh,
  output logic [3:0]                    SC_GOALCTRL_level_Out,
  output logic                          SC_GOALCTRL_busy_OutHigh
);

  localparam int CNT_MAX = (GOALCTRL_SAMPLE_DELAY > GOALCTRL_HOLD_CYCLES) ?
                           GOALCTRL_SAMPLE_DELAY : GOALCTRL_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counters run down to zero, so a delay of N cycles loads N-1.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(GOALCTRL_SAMPLE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(GOALCTRL_HOLD_CYCLES - 1);

  // Walls everywhere except the two home openings (bits 5 and 2).
  localparam logic [GOALCTRL_DATAWIDTH-1:0] BASE_MASK = GOALCTRL_DATAWIDTH'(8'b11011011);

  typedef enum logic [2:0] {
    IDLE, ARMED, SETTLE, DECIDE, RESULT, HOLD, WAIT_CLEAR, CLEAR
  } stateT;

  stateT                         state, stateNext;
  logic [CNT_W-1:0]              cnt, cntNext;
  logic [1:0]                    filledNext;
  logic [GOALCTRL_DATAWIDTH-1:0] entryNext;
  logic                          homeNext, deadNext, clearNext;
  logic [3:0]                    levelNext;

  // A filled home closes its opening so a second frog cannot enter it.
  function automatic logic [GOALCTRL_DATAWIDTH-1:0] maskFor(input logic [1:0] filled);
    logic [GOALCTRL_DATAWIDTH-1:0] m;
    m    = BASE_MASK;
    m[5] = m[5] | filled[1];
    m[2] = m[2] | filled[0];
    return m;
  endfunction

  always_ff @(posedge SC_GOALCTRL_CLOCK_50 or posedge SC_GOALCTRL_RESET_InHigh) begin
    if (SC_GOALCTRL_RESET_InHigh) state <= IDLE;
    else                          state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    filledNext = SC_GOALCTRL_homeFilled_Out;
    entryNext  = SC_GOALCTRL_entryBUS_Out;
    homeNext   = 1'b0;
    deadNext   = 1'b0;
    clearNext  = 1'b0;
    levelNext  = SC_GOALCTRL_level_Out;

    if (SC_GOALCTRL_stop_InHigh) begin
      stateNext  = IDLE;
      cntNext    = '0;
      filledNext = 2'b00;
      entryNext  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (SC_GOALCTRL_start_InHigh) begin
            stateNext  = ARMED;
            filledNext = 2'b00;
            entryNext  = maskFor(2'b00);
          end
        end
        ARMED: begin
          if (SC_GOALCTRL_frogAtTop_InHigh) begin
            stateNext = SETTLE;
            cntNext   = SETTLE_LOAD;
          end
        end
        SETTLE: begin
          // Leaving the row aborts the attempt even on the last settle cycle.
          if (!SC_GOALCTRL_frogAtTop_InHigh) stateNext = ARMED;
          else if (cnt == '0)                stateNext = DECIDE;
          else                               cntNext   = cnt - 1'b1;
        end
        DECIDE: begin
          stateNext = RESULT;
          if (!SC_GOALCTRL_lose_InLow) begin
            deadNext = 1'b1;
          end else if (!SC_GOALCTRL_enterLeft_InLow && !SC_GOALCTRL_homeFilled_Out[1]) begin
            homeNext      = 1'b1;
            filledNext[1] = 1'b1;
          end else if (!SC_GOALCTRL_enterRight_InLow && !SC_GOALCTRL_homeFilled_Out[0]) begin
            homeNext      = 1'b1;
            filledNext[0] = 1'b1;
          end else begin
            deadNext = 1'b1;
          end
          entryNext = maskFor(filledNext);
        end
        RESULT: begin
          stateNext = HOLD;
          cntNext   = HOLD_LOAD;
        end
        HOLD: begin
          if (cnt == '0) stateNext = WAIT_CLEAR;
          else           cntNext   = cnt - 1'b1;
        end
        WAIT_CLEAR: begin
          if (!SC_GOALCTRL_frogAtTop_InHigh) begin
            if (SC_GOALCTRL_homeFilled_Out == 2'b11) begin
              // Clear side effects are registered on entry so they show during CLEAR.
              stateNext  = CLEAR;
              clearNext  = 1'b1;
              filledNext = 2'b00;
              entryNext  = maskFor(2'b00);
              levelNext  = SC_GOALCTRL_level_Out + 4'd1;
            end else begin
              stateNext = ARMED;
            end
          end
        end
        CLEAR:   stateNext = ARMED;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge SC_GOALCTRL_CLOCK_50 or posedge SC_GOALCTRL_RESET_InHigh) begin
    if (SC_GOALCTRL_RESET_InHigh) begin
      cnt                            <= '0;
      SC_GOALCTRL_entryBUS_Out       <= '0;
      SC_GOALCTRL_homeFilled_Out     <= 2'b00;
      SC_GOALCTRL_frogHome_OutHigh   <= 1'b0;
      SC_GOALCTRL_frogDead_OutHigh   <= 1'b0;
      SC_GOALCTRL_levelClear_OutHigh <= 1'b0;
      SC_GOALCTRL_level_Out          <= 4'd0;
    end else begin
      cnt                            <= cntNext;
      SC_GOALCTRL_entryBUS_Out       <= entryNext;
      SC_GOALCTRL_homeFilled_Out     <= filledNext;
      SC_GOALCTRL_frogHome_OutHigh   <= homeNext;
      SC_GOALCTRL_frogDead_OutHigh   <= deadNext;
      SC_GOALCTRL_levelClear_OutHigh <= clearNext;
      SC_GOALCTRL_level_Out          <= levelNext;
    end
  end

  assign SC_GOALCTRL_busy_OutHigh = (state != IDLE) && (state != ARMED);

endmodule
